// File: rtl/fp_normalizer.sv
// Post-add normalize/round stage: carry fix-up, bit-serial left shift,
// round-to-nearest-even, packing to IEEE-754 with N/Z/C/V flags.
module fp_normalizer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [FRAC_W+1:0]     in_man,
    input  logic [2:0]            in_grs,
    output logic [EXP_W+FRAC_W:0] result,
    output logic [3:0]            ALUFlags,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int MW = FRAC_W + 2;
    localparam int XW = EXP_W + 1;
    localparam int RW = 1 + EXP_W + FRAC_W;
    localparam logic [XW-1:0] EXP_INF = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        CARRY,
        SHIFT,
        ROUND,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [XW-1:0]   exp_q, exp_d;
    logic [MW-1:0]   man_q, man_d;
    logic            g_q, g_d;
    logic            r_q, r_d;
    logic            s_q, s_d;
    logic [RW-1:0]   result_q, result_d;
    logic [3:0]      flags_q, flags_d;

    logic              fin;
    logic              f_inf;
    logic              f_zero;
    logic              f_c;
    logic              f_v;
    logic              f_sign;
    logic [EXP_W-1:0]  f_exp;
    logic [FRAC_W-1:0] f_frac;
    logic              inc;
    logic [MW-1:0]     man_r;
    logic [XW-1:0]     exp_r;
    logic [RW-1:0]     pk_res;
    logic              pk_z;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign ALUFlags  = flags_q;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        man_d   = man_q;
        g_d     = g_q;
        r_d     = r_q;
        s_d     = s_q;
        fin     = 1'b0;
        f_inf   = 1'b0;
        f_zero  = 1'b0;
        f_c     = 1'b0;
        f_v     = 1'b0;
        f_sign  = sign_q;
        f_exp   = exp_q[EXP_W-1:0];
        f_frac  = man_q[FRAC_W-1:0];
        inc     = 1'b0;
        man_r   = '0;
        exp_r   = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    exp_d  = {1'b0, in_exp};
                    man_d  = in_man;
                    {g_d, r_d, s_d} = in_grs;
                    f_sign = in_sign;
                    if (in_man == '0 && in_grs == '0) begin
                        fin    = 1'b1;
                        f_zero = 1'b1;
                    end else if (in_exp == EXP_INF[EXP_W-1:0]) begin
                        fin   = 1'b1;
                        f_inf = 1'b1;
                        f_v   = 1'b1;
                    end else if (in_exp == '0) begin
                        fin    = 1'b1;
                        f_zero = 1'b1;
                    end else if (in_man[MW-1]) begin
                        state_d = CARRY;
                    end else if (in_man[MW-2]) begin
                        state_d = ROUND;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            CARRY: begin
                man_d = man_q >> 1;
                g_d   = man_q[0];
                r_d   = g_q;
                s_d   = r_q | s_q;
                exp_d = exp_q + XW'(1);
                if (exp_d == EXP_INF) begin
                    fin   = 1'b1;
                    f_inf = 1'b1;
                    f_v   = 1'b1;
                    f_c   = man_q[0] | g_q | r_q | s_q;
                end else begin
                    state_d = ROUND;
                end
            end
            SHIFT: begin
                // Smallest normal exponent reached: no denormals, so flush.
                if (exp_q == XW'(1)) begin
                    fin    = 1'b1;
                    f_zero = 1'b1;
                end else begin
                    man_d = {man_q[MW-2:0], g_q};
                    g_d   = r_q;
                    r_d   = s_q;
                    exp_d = exp_q - XW'(1);
                    if (man_q[MW-3]) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                inc   = g_q & (r_q | s_q | man_q[0]);
                man_r = man_q + MW'(inc);
                exp_r = exp_q;
                if (man_r[MW-1]) begin
                    man_r = man_r >> 1;
                    exp_r = exp_q + XW'(1);
                end
                fin    = 1'b1;
                f_c    = g_q | r_q | s_q;
                f_exp  = exp_r[EXP_W-1:0];
                f_frac = man_r[FRAC_W-1:0];
                if (exp_r == EXP_INF) begin
                    f_inf = 1'b1;
                    f_v   = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            state_d = DONE;
        end
    end

    always_comb begin
        pk_res = {f_sign, f_exp, f_frac};
        if (f_zero) begin
            pk_res = '0;
        end else if (f_inf) begin
            pk_res = {f_sign, EXP_INF[EXP_W-1:0], {FRAC_W{1'b0}}};
        end
        pk_z = (pk_res[RW-2:0] == '0);
        if (pk_z) begin
            pk_res[RW-1] = 1'b0;
        end
        result_d = result_q;
        flags_d  = flags_q;
        if (fin) begin
            result_d = pk_res;
            flags_d  = {f_sign & ~pk_z, pk_z, f_c, f_v};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            man_q    <= '0;
            g_q      <= 1'b0;
            r_q      <= 1'b0;
            s_q      <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            man_q    <= man_d;
            g_q      <= g_d;
            r_q      <= r_d;
            s_q      <= s_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer: scoreboard of expected results,
// latency, back-pressure hold and async reset mid-operation.
module tb_fp_normalizer;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_man;
    logic [2:0]  in_grs;
    logic [31:0] result;
    logic [3:0]  ALUFlags;
    logic        out_valid;
    logic        out_ready;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        logic [3:0]  mask;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fp_normalizer #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .in_grs    (in_grs),
        .result    (result),
        .ALUFlags  (ALUFlags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic s,
                          input logic [7:0] e, input logic [24:0] m,
                          input logic [2:0] grs, input logic [31:0] er,
                          input logic [3:0] ef, input logic [3:0] mask,
                          input int lat, input bit hold);
        exp_t x;
        int   cyc;
        logic [31:0] r0;
        logic [3:0]  f0;
        x.res   = er;
        x.flags = ef;
        x.mask  = mask;
        x.lat   = lat;
        sb.push_back(x);
        @(negedge clk);
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
        in_grs   = grs;
        in_valid = 1'b1;
        check({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            check({tag, " latency"}, cyc, x.lat);
            check({tag, " result"}, result, x.res);
            check({tag, " flags"}, {28'b0, ALUFlags & x.mask}, {28'b0, x.flags});
        end
        if (hold) begin
            r0 = result;
            f0 = ALUFlags;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                check({tag, " hold result"}, result, r0);
                check({tag, " hold flags"}, {28'b0, ALUFlags}, {28'b0, f0});
                check({tag, " hold in_ready"}, {31'b0, in_ready}, 32'd0);
                check({tag, " hold out_valid"}, {31'b0, out_valid}, 32'd1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " post out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, " post in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        in_grs    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst flags", {28'b0, ALUFlags}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("carry", 1'b0, 8'd127, 25'h1000000, 3'b000,
               32'h40000000, 4'b0000, 4'b1111, 3, 1'b1);
        run_op("shift23", 1'b0, 8'd127, 25'h0000001, 3'b000,
               32'h34000000, 4'b0000, 4'b1111, 25, 1'b0);
        run_op("rnd_up", 1'b0, 8'd127, 25'h0800001, 3'b100,
               32'h3F800002, 4'b0010, 4'b1111, 2, 1'b0);
        run_op("rnd_tie_even", 1'b0, 8'd127, 25'h0800000, 3'b100,
               32'h3F800000, 4'b0010, 4'b1111, 2, 1'b0);
        run_op("rnd_tie_odd_keep", 1'b0, 8'd127, 25'h0800002, 3'b100,
               32'h3F800002, 4'b0010, 4'b1111, 2, 1'b0);
        run_op("rnd_carry_out", 1'b0, 8'd127, 25'h0FFFFFF, 3'b100,
               32'h40000000, 4'b0010, 4'b1111, 2, 1'b0);
        run_op("ovf_pos", 1'b0, 8'd254, 25'h1000000, 3'b000,
               32'h7F800000, 4'b0001, 4'b1111, 2, 1'b0);
        run_op("ovf_neg", 1'b1, 8'd254, 25'h1000000, 3'b000,
               32'hFF800000, 4'b1001, 4'b1111, 2, 1'b0);
        run_op("rnd_ovf", 1'b0, 8'd254, 25'h0FFFFFF, 3'b110,
               32'h7F800000, 4'b0011, 4'b1111, 2, 1'b0);
        run_op("inf_in", 1'b1, 8'd255, 25'h0800000, 3'b000,
               32'hFF800000, 4'b1001, 4'b1101, 1, 1'b0);
        run_op("zero_neg", 1'b1, 8'd100, 25'h0000000, 3'b000,
               32'h00000000, 4'b0100, 4'b1111, 1, 1'b0);
        run_op("flush_exp0", 1'b1, 8'd0, 25'h0800000, 3'b000,
               32'h00000000, 4'b0100, 4'b1100, 1, 1'b0);
        run_op("flush_exp1", 1'b0, 8'd1, 25'h0000001, 3'b000,
               32'h00000000, 4'b0100, 4'b1100, 2, 1'b0);
        run_op("shift1_neg", 1'b1, 8'd130, 25'h0400000, 3'b000,
               32'hC0800000, 4'b1000, 4'b1111, 3, 1'b0);

        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_man   = 25'h0000001;
        in_grs   = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("after_rst", 1'b0, 8'd127, 25'h1000000, 3'b000,
               32'h40000000, 4'b0000, 4'b1111, 3, 1'b0);

        check("sb drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
